// File: rtl/expand_pkg.sv
// Shared definitions for the expansion capture stage: default widths,
// buffer occupancy encodings, the buffered entry layout and sign extension.
package expand_pkg;

    localparam int         W_DEF   = 12;
    localparam int         SW_DEF  = 15;
    localparam logic [7:0] CNT_MAX = 8'd255;

    // Skid buffer occupancy encodings
    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    // One buffered capture: word, tag, post-update running sum, frame index
    typedef struct packed {
        logic [W_DEF-1:0]  word;
        logic [1:0]        tag;
        logic [SW_DEF-1:0] sum;
        logic [7:0]        cnt;
    } cap_entry_t;

    // Sign-extend a default-width word to the default accumulator width
    function automatic logic [SW_DEF-1:0] sext_w2sw(input logic [W_DEF-1:0] w);
        return {{(SW_DEF-W_DEF){w[W_DEF-1]}}, w};
    endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry FIFO skid buffer with a registered head. The head register
// drives the output directly; the second register only holds the entry
// that arrives while the head is stalled.
module skid_buf2
    import expand_pkg::*;
#(
    parameter int DW = $bits(cap_entry_t)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic [1:0]    occ;
    logic [DW-1:0] head;
    logic [DW-1:0] tail;
    logic          push;
    logic          pop;

    // Readiness depends only on registered occupancy, never on out_ready
    assign in_ready  = (occ != OCC_FULL) && !reset;
    assign out_valid = (occ != OCC_EMPTY);
    assign out_data  = head;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Occupancy state machine and head/tail data movement
    always_ff @(posedge clk) begin
        if (reset) begin
            occ  <= OCC_EMPTY;
            head <= '0;
            tail <= '0;
        end else begin
            case (occ)
                OCC_EMPTY: begin
                    if (push) begin
                        head <= in_data;
                        occ  <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        head <= in_data;
                    end else if (push) begin
                        tail <= in_data;
                        occ  <= OCC_FULL;
                    end else if (pop) begin
                        occ  <= OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (pop) begin
                        head <= tail;
                        occ  <= OCC_ONE;
                    end
                end
                default: occ <= OCC_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/expand_capture_pipe.sv
// Registered capture stage behind the expansion block: keeps a running
// per-frame sum and word index, and buffers {word, tag, sum, index} in a
// two-entry skid buffer so consumer back-pressure never reaches upstream
// combinationally.
module expand_capture_pipe
    import expand_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int SW = SW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_word,
    input  logic [1:0]    in_tag,
    input  logic          in_sof,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_word,
    output logic [1:0]    out_tag,
    output logic [SW-1:0] out_sum,
    output logic [7:0]    out_cnt
);

    localparam int EW = W + 2 + SW + 8;

    logic [SW-1:0] acc;
    logic [SW-1:0] acc_base;
    logic [SW-1:0] sext_word;
    logic [SW-1:0] nsum;
    logic [7:0]    cnt;
    logic [7:0]    ncnt;
    logic          accept;
    logic [EW-1:0] entry_in;
    logic [EW-1:0] entry_out;

    assign sext_word = {{(SW-W){in_word[W-1]}}, in_word};
    assign accept    = in_valid && in_ready;

    // Next running sum (modulo 2^SW) and saturating frame index
    always_comb begin
        acc_base = in_sof ? '0 : acc;
        nsum     = acc_base + sext_word;
        if (in_sof) begin
            ncnt = 8'd1;
        end else if (cnt == CNT_MAX) begin
            ncnt = CNT_MAX;
        end else begin
            ncnt = cnt + 8'd1;
        end
    end

    // Accumulator and counter advance only on an accepted word
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            acc <= nsum;
            cnt <= ncnt;
        end
    end

    assign entry_in = {in_word, in_tag, nsum, ncnt};

    skid_buf2 #(
        .DW(EW)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (entry_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (entry_out)
    );

    assign {out_word, out_tag, out_sum, out_cnt} = entry_out;

endmodule

// File: tb/tb_expand_capture_pipe.sv
// Self-checking bench for expand_capture_pipe: a spec-level model pushes
// expected entries on every accept; each test pops and compares on pops.
module tb_expand_capture_pipe;
    import expand_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] in_word = '0;
    logic [1:0]  in_tag = '0;
    logic        in_sof = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] out_word;
    logic [1:0]  out_tag;
    logic [14:0] out_sum;
    logic [7:0]  out_cnt;

    always #5 clk = ~clk;

    expand_capture_pipe #(
        .W (12),
        .SW(15)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_word  (in_word),
        .in_tag   (in_tag),
        .in_sof   (in_sof),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_word (out_word),
        .out_tag  (out_tag),
        .out_sum  (out_sum),
        .out_cnt  (out_cnt)
    );

    typedef struct packed {
        logic        acc;
        logic        pop;
        logic        rdy;
        logic        ov;
        logic [11:0] w;
        logic [1:0]  t;
        logic [14:0] s;
        logic [7:0]  c;
    } snap_t;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    cap_entry_t  sb[$];
    logic [14:0] m_acc = '0;
    logic [7:0]  m_cnt = '0;

    // Drive one cycle of inputs, snapshot outputs mid-cycle, update the model
    task automatic drive_cycle(input logic v, input logic [11:0] w, input logic [1:0] t,
                               input logic sof, input logic ordy, output snap_t s);
        logic [14:0] nsum;
        logic [7:0]  ncnt;
        in_valid  = v;
        in_word   = w;
        in_tag    = t;
        in_sof    = sof;
        out_ready = ordy;
        @(negedge clk);
        s.rdy = in_ready;
        s.ov  = out_valid;
        s.w   = out_word;
        s.t   = out_tag;
        s.s   = out_sum;
        s.c   = out_cnt;
        s.acc = v && in_ready;
        s.pop = out_valid && ordy && !reset;
        if (s.acc) begin
            nsum = (sof ? 15'd0 : m_acc) + {{3{w[11]}}, w};
            ncnt = sof ? 8'd1 : ((m_cnt == 8'd255) ? 8'd255 : m_cnt + 8'd1);
            m_acc = nsum;
            m_cnt = ncnt;
            sb.push_back({w, t, nsum, ncnt});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        snap_t s;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 12'hABC, 2'd3, 1'b1, 1'b1, s);
            n_cmp++;
            if ({s.rdy, s.ov, s.w, s.t, s.s, s.c} !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs: got rdy=%b ov=%b w=%h t=%h s=%h c=%h required all 0",
                         s.rdy, s.ov, s.w, s.t, s.s, s.c);
            end
        end
        reset = 1'b0;
        drive_cycle(1'b0, 12'h000, 2'd0, 1'b0, 1'b0, s);
        n_cmp++;
        if ({s.rdy, s.ov} !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_release: got rdy=%b ov=%b required rdy=1 ov=0", s.rdy, s.ov);
        end
    endtask

    task automatic test_basic();
        snap_t s;
        cap_entry_t e;
        drive_cycle(1'b1, 12'h001, 2'd1, 1'b1, 1'b1, s);
        n_cmp++;
        if (s.acc !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_accept0: got accept=%b required 1", s.acc);
        end
        drive_cycle(1'b1, 12'hFFF, 2'd2, 1'b0, 1'b1, s);
        n_cmp++;
        if (!s.pop || sb.size() == 0) begin
            n_bad++;
            $display("FAIL basic_latency0: got out_valid=%b required 1 one cycle after accept", s.ov);
        end else begin
            e = sb.pop_front();
            if ({s.w, s.t, s.s, s.c} !== {12'h001, 2'd1, 15'h0001, 8'd1} ||
                {s.w, s.t, s.s, s.c} !== e) begin
                n_bad++;
                $display("FAIL basic_out0: got %h required %h", {s.w, s.t, s.s, s.c}, e);
            end
        end
        drive_cycle(1'b0, 12'h000, 2'd0, 1'b0, 1'b1, s);
        n_cmp++;
        if (!s.pop || sb.size() == 0) begin
            n_bad++;
            $display("FAIL basic_latency1: got out_valid=%b required 1 one cycle after accept", s.ov);
        end else begin
            e = sb.pop_front();
            if ({s.w, s.t, s.s, s.c} !== {12'hFFF, 2'd2, 15'h0000, 8'd2} ||
                {s.w, s.t, s.s, s.c} !== e) begin
                n_bad++;
                $display("FAIL basic_out1: got %h required %h", {s.w, s.t, s.s, s.c}, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        snap_t s;
        cap_entry_t e;
        logic [11:0] wv [3] = '{12'h123, 12'h456, 12'h789};
        int unsigned k = 0;
        int first_pop = -1;
        int third_acc = -1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            drive_cycle(k < 3, (k < 3) ? wv[k] : 12'h000, 2'(k), 1'b0, cyc >= 4, s);
            if (cyc == 2 || cyc == 3) begin
                n_cmp++;
                if (s.rdy !== 1'b0 || s.ov !== 1'b1 || s.w !== wv[0]) begin
                    n_bad++;
                    $display("FAIL bp_stall: cyc %0d got rdy=%b ov=%b w=%h required rdy=0 ov=1 w=%h",
                             cyc, s.rdy, s.ov, s.w, wv[0]);
                end
            end
            if (s.acc) begin
                if (k == 2) third_acc = cyc;
                k++;
            end
            if (s.pop) begin
                if (first_pop < 0) first_pop = cyc;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL bp_pop: got pop with no expected entry");
                end else begin
                    e = sb.pop_front();
                    if ({s.w, s.t, s.s, s.c} !== e) begin
                        n_bad++;
                        $display("FAIL bp_entry: got %h required %h", {s.w, s.t, s.s, s.c}, e);
                    end
                end
            end
        end
        n_cmp++;
        if (first_pop != 4 || third_acc != first_pop + 1 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL bp_timing: got first_pop=%0d third_accept=%0d left=%0d required 4 5 0",
                     first_pop, third_acc, sb.size());
        end
    endtask

    task automatic test_wrap();
        snap_t s;
        cap_entry_t e;
        int unsigned k = 0;
        int unsigned npop = 0;
        int last_acc_cyc = -1;
        logic [14:0] last_sum = '0;
        logic [7:0] last_cnt = '0;
        for (int cyc = 0; cyc < 40 && (k < 10 || sb.size() != 0); cyc++) begin
            drive_cycle(k < 10, 12'h7FF, 2'(k), k == 0, 1'b1, s);
            if (s.acc) begin
                k++;
                last_acc_cyc = cyc;
            end
            if (s.pop) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL wrap_pop: got pop with no expected entry");
                end else begin
                    e = sb.pop_front();
                    npop++;
                    last_sum = s.s;
                    last_cnt = s.c;
                    if ({s.w, s.t, s.s, s.c} !== e || s.c !== 8'(npop)) begin
                        n_bad++;
                        $display("FAIL wrap_entry: got %h cnt=%0d required %h cnt=%0d",
                                 {s.w, s.t, s.s, s.c}, s.c, e, npop);
                    end
                end
            end
        end
        n_cmp++;
        if (last_sum !== 15'h4FF6 || last_cnt !== 8'd10 || last_acc_cyc != 9 || sb.size() != 0) begin
            n_bad++;
            $display("FAIL wrap_final: got sum=%h cnt=%0d last_accept_cyc=%0d required 4ff6 10 9",
                     last_sum, last_cnt, last_acc_cyc);
        end
    endtask

    task automatic test_saturation();
        snap_t s;
        cap_entry_t e;
        int unsigned k = 0;
        int unsigned npop = 0;
        logic [7:0] last_cnt = '0;
        for (int cyc = 0; cyc < 2000 && (k < 300 || sb.size() != 0); cyc++) begin
            drive_cycle(k < 300, 12'($urandom), 2'($urandom), 1'b0, $urandom_range(0, 3) != 0, s);
            if (s.acc) k++;
            if (s.pop) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL sat_pop: got pop with no expected entry");
                end else begin
                    e = sb.pop_front();
                    npop++;
                    last_cnt = s.c;
                    if ({s.w, s.t, s.s, s.c} !== e) begin
                        n_bad++;
                        $display("FAIL sat_entry: got %h required %h", {s.w, s.t, s.s, s.c}, e);
                    end
                end
            end
        end
        n_cmp++;
        if (last_cnt !== 8'd255 || npop != 300) begin
            n_bad++;
            $display("FAIL sat_final: got cnt=%0d pops=%0d required 255 300", last_cnt, npop);
        end
    endtask

    task automatic test_reset_full();
        snap_t s;
        cap_entry_t e;
        drive_cycle(1'b1, 12'h0A0, 2'd1, 1'b1, 1'b0, s);
        drive_cycle(1'b1, 12'h0B0, 2'd2, 1'b0, 1'b0, s);
        drive_cycle(1'b1, 12'h0C0, 2'd3, 1'b0, 1'b0, s);
        n_cmp++;
        if (s.rdy !== 1'b0 || s.ov !== 1'b1) begin
            n_bad++;
            $display("FAIL rf_full: got rdy=%b ov=%b required 0 1", s.rdy, s.ov);
        end
        reset = 1'b1;
        drive_cycle(1'b1, 12'h0C0, 2'd3, 1'b0, 1'b1, s);
        reset = 1'b0;
        sb.delete();
        m_acc = '0;
        m_cnt = '0;
        drive_cycle(1'b0, 12'h000, 2'd0, 1'b0, 1'b1, s);
        n_cmp++;
        if ({s.rdy, s.ov, s.w, s.t, s.s, s.c} !== {1'b1, 1'b0, 37'd0}) begin
            n_bad++;
            $display("FAIL rf_after: got rdy=%b ov=%b w=%h s=%h c=%h required rdy=1 rest 0",
                     s.rdy, s.ov, s.w, s.s, s.c);
        end
        drive_cycle(1'b1, 12'h855, 2'd2, 1'b0, 1'b1, s);
        drive_cycle(1'b0, 12'h000, 2'd0, 1'b0, 1'b1, s);
        n_cmp++;
        if (!s.pop || sb.size() == 0) begin
            n_bad++;
            $display("FAIL rf_first: got out_valid=%b required 1", s.ov);
        end else begin
            e = sb.pop_front();
            if (s.s !== 15'h7855 || s.c !== 8'd1 || {s.w, s.t, s.s, s.c} !== e) begin
                n_bad++;
                $display("FAIL rf_first_sum: got sum=%h cnt=%0d required 7855 1", s.s, s.c);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_wrap();
        test_saturation();
        test_reset_full();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
